// File: rtl/rect_layer_draw.sv
// Multi-rectangle compositor for the VGA pixel path.
// Holds NUM_RECTS rectangles in a double-buffered attribute store. A shadow
// bank takes configuration writes and is copied to the active bank on each
// frame tick. A 2-stage pipeline returns {colour, hit} for the
// highest-priority rectangle (index 0 is highest) that covers the pixel.
module rect_layer_draw #(
  parameter int NUM_RECTS    = 4,
  parameter int COORD_W      = 10,
  parameter int COLOR_W      = 9,
  parameter int FLASH_FRAMES = 30,
  parameter int IDX_W        = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic               video_on,
  input  logic               frame_tick,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [COORD_W-1:0] cfg_x1,
  input  logic [COORD_W-1:0] cfg_y1,
  input  logic [COORD_W-1:0] cfg_x2,
  input  logic [COORD_W-1:0] cfg_y2,
  input  logic [COLOR_W-1:0] cfg_color,
  input  logic               cfg_en,
  input  logic               cfg_flash,
  output logic               flash_phase,
  output logic [COLOR_W:0]   RGBt
);

  localparam int FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_FRAMES - 1);
  // Wide enough to hold NUM_RECTS itself, so out-of-range indices compare correctly.
  localparam logic [IDX_W:0] NUM_RECTS_W = (IDX_W + 1)'(NUM_RECTS);

  // Shadow bank (written by configuration)
  logic [COORD_W-1:0] sh_x1    [NUM_RECTS];
  logic [COORD_W-1:0] sh_y1    [NUM_RECTS];
  logic [COORD_W-1:0] sh_x2    [NUM_RECTS];
  logic [COORD_W-1:0] sh_y2    [NUM_RECTS];
  logic [COLOR_W-1:0] sh_color [NUM_RECTS];
  logic [NUM_RECTS-1:0] sh_en;
  logic [NUM_RECTS-1:0] sh_flash;

  // Active bank (used by the hit test)
  logic [COORD_W-1:0] act_x1    [NUM_RECTS];
  logic [COORD_W-1:0] act_y1    [NUM_RECTS];
  logic [COORD_W-1:0] act_x2    [NUM_RECTS];
  logic [COORD_W-1:0] act_y2    [NUM_RECTS];
  logic [COLOR_W-1:0] act_color [NUM_RECTS];
  logic [NUM_RECTS-1:0] act_en;
  logic [NUM_RECTS-1:0] act_flash;

  logic [FLASH_W-1:0] flash_cnt;

  logic [NUM_RECTS-1:0] hit;
  logic [NUM_RECTS-1:0] s1_hit;
  logic [COLOR_W-1:0]   s1_color [NUM_RECTS];
  logic                 s1_video_on;

  logic [COLOR_W-1:0] win_color;
  logic               any_hit;

  logic wr_ok;
  assign wr_ok = cfg_we && ({1'b0, cfg_idx} < NUM_RECTS_W);

  // Shadow writes and frame-synchronous shadow-to-active copy.
  // NOTE: the attribute store is a register file, not RAM, so every entry is
  // reset; a disabled-at-reset rectangle is what keeps the output blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        sh_x1[i]     <= '0;
        sh_y1[i]     <= '0;
        sh_x2[i]     <= '0;
        sh_y2[i]     <= '0;
        sh_color[i]  <= '0;
        act_x1[i]    <= '0;
        act_y1[i]    <= '0;
        act_x2[i]    <= '0;
        act_y2[i]    <= '0;
        act_color[i] <= '0;
      end
      sh_en     <= '0;
      sh_flash  <= '0;
      act_en    <= '0;
      act_flash <= '0;
    end else begin
      // NOTE: non-blocking assignment means a copy coinciding with a write
      // takes the pre-write shadow value; the write shows a frame later.
      if (frame_tick) begin
        for (int i = 0; i < NUM_RECTS; i++) begin
          act_x1[i]    <= sh_x1[i];
          act_y1[i]    <= sh_y1[i];
          act_x2[i]    <= sh_x2[i];
          act_y2[i]    <= sh_y2[i];
          act_color[i] <= sh_color[i];
        end
        act_en    <= sh_en;
        act_flash <= sh_flash;
      end
      if (wr_ok) begin
        sh_x1[cfg_idx]    <= cfg_x1;
        sh_y1[cfg_idx]    <= cfg_y1;
        sh_x2[cfg_idx]    <= cfg_x2;
        sh_y2[cfg_idx]    <= cfg_y2;
        sh_color[cfg_idx] <= cfg_color;
        sh_en[cfg_idx]    <= cfg_en;
        sh_flash[cfg_idx] <= cfg_flash;
      end
    end
  end

  // Flash timer: flash_phase toggles after every FLASH_FRAMES frame ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_tick) begin
      if (flash_cnt == FLASH_LAST) begin
        flash_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end

  // Per-rectangle hit test on half-open bounds; empty bounds never hit.
  // NOTE: defaulting hit before the loop keeps this block free of latches.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      hit[i] = act_en[i]
             && (X >= act_x1[i]) && (X < act_x2[i])
             && (Y >= act_y1[i]) && (Y < act_y2[i])
             && !(act_flash[i] && flash_phase);
    end
  end

  // Stage 1: register the hit vector, colours and video_on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hit      <= '0;
      s1_video_on <= 1'b0;
      for (int i = 0; i < NUM_RECTS; i++) s1_color[i] <= '0;
    end else begin
      s1_hit      <= hit;
      s1_video_on <= video_on;
      for (int i = 0; i < NUM_RECTS; i++) s1_color[i] <= act_color[i];
    end
  end

  // Priority select: scanning from the top index down leaves the lowest hit index.
  always_comb begin
    win_color = '0;
    any_hit   = 1'b0;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        win_color = s1_color[i];
        any_hit   = 1'b1;
      end
    end
  end

  // Stage 2: register {colour, hit}, blanked outside the visible area.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RGBt <= '0;
    end else if (any_hit && s1_video_on) begin
      RGBt <= {win_color, 1'b1};
    end else begin
      RGBt <= '0;
    end
  end

endmodule

// File: tb/tb_rect_layer_draw.sv
// Directed self-checking bench for rect_layer_draw.
// Uses NUM_RECTS = 3, so index 3 is a representable out-of-range index, and
// FLASH_FRAMES = 2.
module tb_rect_layer_draw;

  localparam int NUM_RECTS    = 3;
  localparam int COORD_W      = 10;
  localparam int COLOR_W      = 9;
  localparam int FLASH_FRAMES = 2;
  localparam int IDX_W        = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [COORD_W-1:0] X, Y;
  logic               video_on;
  logic               frame_tick;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [COORD_W-1:0] cfg_x1, cfg_y1, cfg_x2, cfg_y2;
  logic [COLOR_W-1:0] cfg_color;
  logic               cfg_en, cfg_flash;
  logic               flash_phase;
  logic [COLOR_W:0]   RGBt;

  int compared   = 0;
  int mismatched = 0;

  rect_layer_draw #(
    .NUM_RECTS(NUM_RECTS), .COORD_W(COORD_W), .COLOR_W(COLOR_W),
    .FLASH_FRAMES(FLASH_FRAMES), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .X(X), .Y(Y), .video_on(video_on),
    .frame_tick(frame_tick), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x1(cfg_x1), .cfg_y1(cfg_y1), .cfg_x2(cfg_x2), .cfg_y2(cfg_y2),
    .cfg_color(cfg_color), .cfg_en(cfg_en), .cfg_flash(cfg_flash),
    .flash_phase(flash_phase), .RGBt(RGBt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [IDX_W-1:0] idx, input int x1, input int y1,
                    input int x2, input int y2, input logic [COLOR_W-1:0] col,
                    input logic en, input logic fl);
    cfg_idx = idx;
    cfg_x1 = COORD_W'(x1); cfg_y1 = COORD_W'(y1);
    cfg_x2 = COORD_W'(x2); cfg_y2 = COORD_W'(y2);
    cfg_color = col; cfg_en = en; cfg_flash = fl;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Apply a pixel, wait the 2-clock latency, compare RGBt.
  task automatic pix(input string tag, input int x, input int y, input logic [15:0] exp);
    X = COORD_W'(x);
    Y = COORD_W'(y);
    step(2);
    check(tag, 16'(RGBt), exp);
  endtask

  initial begin
    rst_n = 1'b0; X = '0; Y = '0; video_on = 1'b1; frame_tick = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_x1 = '0; cfg_y1 = '0; cfg_x2 = '0; cfg_y2 = '0;
    cfg_color = '0; cfg_en = 1'b0; cfg_flash = 1'b0;
    #12;
    check("reset_rgbt", 16'(RGBt), 16'h0);
    check("reset_phase", 16'(flash_phase), 16'h0);
    rst_n = 1'b1;
    step();

    // Shadow write is invisible until a frame tick.
    wr(0, 10, 20, 50, 60, 9'h1FF, 1'b1, 1'b0);
    pix("pre_tick", 10, 20, 16'h000);
    tick();                                   // tick 1: cnt=1, phase 0
    pix("post_tick_miss", 9, 20, 16'h000);
    X = 10'd10;
    step();
    check("latency_1clk", 16'(RGBt), 16'h000);
    step();
    check("latency_2clk", 16'(RGBt), 16'h3FF);

    // Half-open boundaries.
    pix("x9",  9,  20, 16'h000);
    pix("x10", 10, 20, 16'h3FF);
    pix("x49", 49, 20, 16'h3FF);
    pix("x50", 50, 20, 16'h000);
    pix("y19", 10, 19, 16'h000);
    pix("y20", 10, 20, 16'h3FF);
    pix("y59", 10, 59, 16'h3FF);
    pix("y60", 10, 60, 16'h000);

    // Empty rectangle (x1 == x2) never hits.
    wr(1, 60, 30, 60, 40, 9'h055, 1'b1, 1'b0);
    tick();                                   // tick 2: wrap, phase 1
    pix("empty_rect", 60, 35, 16'h000);
    check("phase_after_2", 16'(flash_phase), 16'h1);

    // Overlap: lower index wins.
    wr(0, 20, 20, 50, 50, 9'h007, 1'b1, 1'b0);
    wr(1, 30, 30, 40, 40, 9'h1C0, 1'b1, 1'b0);
    tick();                                   // tick 3: cnt=1, phase 1
    pix("overlap_idx0", 35, 35, 16'h00F);
    wr(0, 20, 20, 50, 50, 9'h007, 1'b0, 1'b0);
    tick();                                   // tick 4: wrap, phase 0
    pix("overlap_idx1", 35, 35, 16'h381);
    video_on = 1'b0;
    pix("video_off", 35, 35, 16'h000);
    video_on = 1'b1;

    // Flash: idx0 flashes, idx1 steady underneath.
    wr(0, 20, 20, 50, 50, 9'h007, 1'b1, 1'b1);
    tick();                                   // tick 5: cnt=1, phase 0
    pix("flash_p0_a", 35, 35, 16'h00F);
    check("flash_phase_0a", 16'(flash_phase), 16'h0);
    tick();                                   // tick 6: wrap, phase 1
    check("flash_phase_1", 16'(flash_phase), 16'h1);
    pix("flash_hidden", 35, 35, 16'h381);
    tick();                                   // tick 7
    tick();                                   // tick 8: wrap, phase 0
    check("flash_phase_0b", 16'(flash_phase), 16'h0);
    pix("flash_shown", 35, 35, 16'h00F);

    // Write coinciding with frame tick: copy takes the old shadow.
    cfg_idx = 2'd0; cfg_x1 = 10'd20; cfg_y1 = 10'd20; cfg_x2 = 10'd50; cfg_y2 = 10'd50;
    cfg_color = 9'h0AA; cfg_en = 1'b1; cfg_flash = 1'b0;
    cfg_we = 1'b1; frame_tick = 1'b1;         // tick 9: cnt=1, phase 0
    step();
    cfg_we = 1'b0; frame_tick = 1'b0;
    pix("coincide_old", 35, 35, 16'h00F);
    tick();                                   // tick 10: wrap, phase 1
    pix("coincide_new", 35, 35, 16'h155);

    // Out-of-range index leaves state unchanged.
    wr(2'd3, 0, 0, 100, 100, 9'h1FF, 1'b1, 1'b0);
    tick();                                   // tick 11: cnt=1, phase 1
    pix("oor_keep", 35, 35, 16'h155);
    pix("oor_nohit", 5, 5, 16'h000);

    // Mid-frame asynchronous reset.
    check("pre_reset_rgbt", 16'(RGBt), 16'h000);
    pix("pre_reset_hit", 35, 35, 16'h155);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rgbt", 16'(RGBt), 16'h000);
    check("async_phase", 16'(flash_phase), 16'h0);
    check("async_act_en", 16'(dut.act_en), 16'h0);
    #4;
    rst_n = 1'b1;
    step();
    pix("post_reset", 35, 35, 16'h000);
    tick();
    pix("post_reset_tick", 35, 35, 16'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
